// File: rtl/pa3_button_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pa3_button_pkg
// Purpose  : Shared types and helpers for the pushbutton debounce path.
// Revision : 1.0
// ============================================================================
package pa3_button_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } debounce_state_t;

    function automatic integer debounce_cycles(input real freq_hz, input real time_s);
        return integer'(freq_hz * time_s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pa3_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : pa3_debounce_channel
// Purpose  : One channel: 2-flop synchronizer, debounce FSM and stable counter.
// Revision : 1.0
// ============================================================================
module pa3_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int CWIDTH          = 19
) (
    input  logic clk_40mhz,
    input  logic rstN,
    input  logic din,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    import pa3_button_pkg::*;

    localparam logic [CWIDTH-1:0] c_last_count = CWIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]        r_sync;
    logic              w_s;
    debounce_state_t   r_state, w_state_nxt;
    logic [CWIDTH-1:0] r_count, w_count_nxt;
    logic              r_level, w_level_nxt;
    logic              r_press, w_press_nxt;
    logic              r_release, w_release_nxt;

    assign w_s = r_sync[1];

    always_ff @(posedge clk_40mhz or negedge rstN) begin
        if (!rstN) begin
            r_sync    <= 2'b00;
            r_state   <= STABLE_LO;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], din};
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Counter is cleared on every WAIT entry and exit, so it can never wrap.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HI;
                    w_count_nxt = '0;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_count_nxt = '0;
                end else if (r_count == c_last_count) begin
                    w_state_nxt = STABLE_HI;
                    w_count_nxt = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + CWIDTH'(1);
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LO;
                    w_count_nxt = '0;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_count_nxt = '0;
                end else if (r_count == c_last_count) begin
                    w_state_nxt   = STABLE_LO;
                    w_count_nxt   = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + CWIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_count_nxt = '0;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule
`default_nettype wire

// File: rtl/pa3_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pa3_button_debounce
// Purpose  : Debounced level plus press/release pulses for NUM_INPUTS pins.
// Revision : 1.0
// ============================================================================
module pa3_button_debounce #(
    parameter int  NUM_INPUTS    = 4,
    parameter real CLK_FREQUENCY = 40.0e6,
    parameter real DEBOUNCE_TIME = 10.0e-3,
    parameter int  ACTIVE_LOW    = 1
) (
    input  logic                  clk_40mhz,
    input  logic                  rstN,
    input  logic [NUM_INPUTS-1:0] btn_pin,
    output logic [NUM_INPUTS-1:0] btn_level,
    output logic [NUM_INPUTS-1:0] btn_press,
    output logic [NUM_INPUTS-1:0] btn_release
);
    import pa3_button_pkg::*;

    localparam int DEBOUNCE_CYCLES = debounce_cycles(CLK_FREQUENCY, DEBOUNCE_TIME);
    localparam int CWIDTH          = integer'($clog2(DEBOUNCE_CYCLES));

    logic [NUM_INPUTS-1:0] w_in;

    // Internally 1 always means "pressed".
    assign w_in = (ACTIVE_LOW != 0) ? ~btn_pin : btn_pin;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        pa3_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CWIDTH          (CWIDTH)
        ) u_channel (
            .clk_40mhz   (clk_40mhz),
            .rstN        (rstN),
            .din         (w_in[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g])
        );
    end

endmodule
`default_nettype wire
